// File: rtl/isa_pkg.sv
// Shared instruction-store definitions: 9-bit {op,r1,r2} word layout and loader states.
package isa_pkg;

   localparam int INSTR_W = 9;
   localparam int FIELD_W = 3;

   typedef struct packed {
      logic [FIELD_W-1:0] op;
      logic [FIELD_W-1:0] r1;
      logic [FIELD_W-1:0] r2;
   } instr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } load_state_t;

endpackage

// File: rtl/instr_assembler.sv
// Packs three accepted 3-bit fields (op, r1, r2) into one instr_t; word_valid marks
// the beat that delivers r2, with the word presented combinationally on that beat.
module instr_assembler
   import isa_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               accept,
   input  logic [FIELD_W-1:0] field,
   output instr_t             word,
   output logic               word_valid
);

   logic [1:0]         beat;
   logic [FIELD_W-1:0] op_q;
   logic [FIELD_W-1:0] r1_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         beat <= 2'd0;
         op_q <= '0;
         r1_q <= '0;
      end else if (accept) begin
         case (beat)
            2'd0: begin
               op_q <= field;
               beat <= 2'd1;
            end
            2'd1: begin
               r1_q <= field;
               beat <= 2'd2;
            end
            default: beat <= 2'd0;
         endcase
      end
   end

   // r2 bypasses storage so the top can register the word in the accept cycle.
   assign word_valid = accept && (beat == 2'd2);
   assign word       = {op_q, r1_q, field};

endmodule

// File: rtl/program_loader.sv
// Host-stream program loader: packs field triples and writes them to consecutive
// addresses. Define PROGRAM_LOADER_CHECKSUM_EN to add an XOR checksum output.
module program_loader
   import isa_pkg::*;
#(
   parameter int PC_BITS = 12
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PC_BITS-1:0]   base_addr,
   input  logic [PC_BITS:0]     num_words,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic [FIELD_W-1:0]   in_field,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [PC_BITS-1:0]   wr_addr,
   output logic [INSTR_W-1:0]   wr_data,
   output logic                 busy,
   output logic                 done
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   ,
   output logic [INSTR_W-1:0]   checksum
`endif
);

   localparam logic [PC_BITS-1:0] ADDR_ONE  = 1;
   localparam logic [PC_BITS:0]   COUNT_ONE = 1;

   load_state_t      state;
   logic [PC_BITS:0] count;
   logic [PC_BITS:0] count_next;
   logic [PC_BITS:0] num_q;
   logic             accept;
   logic             start_now;
   logic             asm_clear;
   instr_t           word;
   logic             word_valid;

   assign accept     = in_valid && in_ready;
   assign start_now  = (state == IDLE) && start && !abort;
   assign asm_clear  = start_now || abort;
   assign count_next = count + COUNT_ONE;

   instr_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear),
      .accept     (accept),
      .field      (in_field),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         count    <= '0;
         num_q    <= '0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_now) begin
                  wr_addr <= base_addr;
                  num_q   <= num_words;
                  count   <= '0;
                  if (num_words == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (abort) begin
                  state    <= IDLE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
               end else if (word_valid) begin
                  state    <= WRITE;
                  in_ready <= 1'b0;
                  wr_en    <= 1'b1;
                  wr_data  <= word;
               end
            end
            WRITE: begin
               // The strobe for this word is already on the bus, so abort only stops what follows.
               wr_addr <= wr_addr + ADDR_ONE;
               count   <= count_next;
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (count_next < num_q) begin
                  state    <= LOAD;
                  in_ready <= 1'b1;
               end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || start_now) checksum <= '0;
      else if (wr_en)         checksum <= checksum ^ wr_data;
   end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of two-word loads plus hand sequences for
// num_words=0, abort/restart, abort+start collision and reset mid-load.
module tb_program_loader;

   localparam int PB = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [PB-1:0] base_addr = '0;
   logic [PB:0]   num_words = '0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic [2:0]    in_field = '0;
   logic          in_ready;
   logic          wr_en;
   logic [PB-1:0] wr_addr;
   logic [8:0]    wr_data;
   logic          busy;
   logic          done;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [8:0]    checksum;
`endif

   program_loader #(.PC_BITS(PB)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_field  (in_field),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [PB-1:0] wa[$];
   logic [8:0]    wd[$];
   int            wc[$];
   int            done_n;
   int            done_cyc;

   // Write/done monitor; a strobe must never coincide with in_ready or an idle loader.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
            checks = checks + 1;
            if (in_ready || !busy) begin
               errors = errors + 1;
               $display("FAIL write_state: in_ready=%0b busy=%0b, required in_ready=0 busy=1", in_ready, busy);
            end
         end
         if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      done_n   = 0;
      done_cyc = -1;
   endtask

   task automatic do_start(input logic [PB-1:0] b, input logic [PB:0] n);
      start     = 1'b1;
      base_addr = b;
      num_words = n;
      tick();
      start = 1'b0;
   endtask

   // Fields are left-aligned in a 6-field vector; returns the cycle of the last accept.
   task automatic feed(input logic [17:0] fields, input int nf, input bit toggle, output int last_acc);
      int  i = 0;
      int  guard = 0;
      bit  ph = 1'b1;
      bit  acc;
      last_acc = -1;
      while (i < nf && guard < 200) begin
         in_valid = toggle ? ph : 1'b1;
         in_field = fields[17-3*i -: 3];
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            last_acc = cyc - 1;
            i = i + 1;
         end
         ph = ~ph;
         guard = guard + 1;
      end
      in_valid = 1'b0;
      if (guard >= 200) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL feed_timeout: accepted %0d fields, expected %0d", i, nf);
      end
   endtask

   typedef struct {
      logic [PB-1:0] base;
      logic [17:0]   fields;
      bit            toggle;
      logic [PB-1:0] a0;
      logic [8:0]    d0;
      logic [PB-1:0] a1;
      logic [8:0]    d1;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int last;

      vecs[0] = '{base: 12'h000, fields: {3'd5,3'd1,3'd2,3'd0,3'd3,3'd7}, toggle: 1'b0,
                  a0: 12'h000, d0: 9'h14A, a1: 12'h001, d1: 9'h01F};
      vecs[1] = '{base: 12'hFFF, fields: {3'd5,3'd1,3'd2,3'd0,3'd3,3'd7}, toggle: 1'b0,
                  a0: 12'hFFF, d0: 9'h14A, a1: 12'h000, d1: 9'h01F};
      vecs[2] = '{base: 12'h010, fields: {3'd5,3'd1,3'd2,3'd0,3'd3,3'd7}, toggle: 1'b1,
                  a0: 12'h010, d0: 9'h14A, a1: 12'h011, d1: 9'h01F};
      vecs[3] = '{base: 12'h123, fields: {3'd7,3'd7,3'd7,3'd0,3'd0,3'd1}, toggle: 1'b0,
                  a0: 12'h123, d0: 9'h1FF, a1: 12'h124, d1: 9'h001};

      clear_log();
      tick(); tick(); tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_wr_en",    wr_en,    0);
      check("rst_busy",     busy,     0);
      check("rst_done",     done,     0);
      check("rst_wr_addr",  wr_addr,  0);
      check("rst_wr_data",  wr_data,  0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
      reset = 1'b0;
      tick();

      for (int v = 0; v < 4; v++) begin
         clear_log();
         do_start(vecs[v].base, 13'd2);
         check("load_busy", busy, 1);
         feed(vecs[v].fields, 6, vecs[v].toggle, last);
         tick();
         check("done_pulse", done, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         check("checksum", checksum, vecs[v].d0 ^ vecs[v].d1);
`endif
         tick();
         check("done_clear", done, 0);
         check("idle_busy", busy, 0);
         tick();
         check("write_count", wa.size(), 2);
         check("done_count", done_n, 1);
         check("done_latency", done_cyc, last + 2);
         if (wa.size() == 2) begin
            check("addr0", wa[0], vecs[v].a0);
            check("data0", wd[0], vecs[v].d0);
            check("addr1", wa[1], vecs[v].a1);
            check("data1", wd[1], vecs[v].d1);
            check("wr_latency", wc[1], last + 1);
            if (!vecs[v].toggle) check("throughput", wc[1] - wc[0], 4);
         end
      end

      // num_words = 0 completes immediately with no write
      clear_log();
      do_start(12'h055, 13'd0);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      tick();
      check("zero_done_clear", done, 0);
      tick();
      check("zero_writes", wa.size(), 0);
      check("zero_done_count", done_n, 1);

      // abort after two fields discards the partial word
      clear_log();
      do_start(12'h200, 13'd2);
      feed({3'd5,3'd1,12'd0}, 2, 1'b0, last);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_field = 3'd3;
      tick(); tick(); tick();
      in_valid = 1'b0;
      check("abort_writes", wa.size(), 0);
      check("abort_done", done_n, 0);

      // restart loads from beat 0; a start while busy must not relatch base
      clear_log();
      do_start(12'h300, 13'd1);
      start     = 1'b1;
      base_addr = 12'h007;
      num_words = 13'd5;
      feed({3'd6,3'd2,3'd4,9'd0}, 3, 1'b0, last);
      start = 1'b0;
      tick(); tick(); tick();
      check("restart_writes", wa.size(), 1);
      check("restart_done", done_n, 1);
      if (wa.size() == 1) begin
         check("restart_addr", wa[0], 12'h300);
         check("restart_data", wd[0], 9'h194);
      end

      // abort wins over start in IDLE
      clear_log();
      abort = 1'b1;
      start = 1'b1;
      num_words = 13'd1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_start_busy", busy, 0);
      check("abort_start_ready", in_ready, 0);
      tick();
      check("abort_start_done", done_n, 0);

      // reset mid-load drops the partial word
      clear_log();
      do_start(12'h400, 13'd1);
      feed({3'd1,3'd2,12'd0}, 2, 1'b0, last);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_addr", wr_addr, 0);
      in_valid = 1'b1;
      in_field = 3'd7;
      tick(); tick(); tick();
      in_valid = 1'b0;
      check("midrst_writes", wa.size(), 0);
      check("midrst_done", done_n, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
